// File: rtl/dispatch_host_pkg.sv
// Shared constants for the dispatcher host interface: descriptor field widths,
// packed-descriptor bit offsets and the arbiter FSM encoding.
package dispatch_host_pkg;

    localparam int WF_COUNT_WIDTH  = 4;
    localparam int VGPR_ID_WIDTH   = 8;
    localparam int SGPR_ID_WIDTH   = 4;
    localparam int LDS_ID_WIDTH    = 8;
    localparam int GDS_ID_WIDTH    = 14;
    localparam int WAVE_ITEM_WIDTH = 6;
    localparam int MEM_ADDR_WIDTH  = 32;

    // Offsets are LSB positions; start_pc sits at the bottom, num_wf at the top.
    localparam int OFF_START_PC    = 0;
    localparam int OFF_WF_SIZE     = OFF_START_PC    + MEM_ADDR_WIDTH;
    localparam int OFF_GDS_TOTAL   = OFF_WF_SIZE     + WAVE_ITEM_WIDTH;
    localparam int OFF_LDS_TOTAL   = OFF_GDS_TOTAL   + GDS_ID_WIDTH + 1;
    localparam int OFF_SGPR_TOTAL  = OFF_LDS_TOTAL   + LDS_ID_WIDTH + 1;
    localparam int OFF_SGPR_PER_WF = OFF_SGPR_TOTAL  + SGPR_ID_WIDTH + 1;
    localparam int OFF_VGPR_TOTAL  = OFF_SGPR_PER_WF + SGPR_ID_WIDTH + 1;
    localparam int OFF_VGPR_PER_WF = OFF_VGPR_TOTAL  + VGPR_ID_WIDTH + 1;
    localparam int OFF_NUM_WF      = OFF_VGPR_PER_WF + VGPR_ID_WIDTH + 1;
    localparam int DESC_WIDTH      = OFF_NUM_WF      + WF_COUNT_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wg_id_pool.sv
// Workgroup id pool: free bitmap with lowest-free allocation, per-id owner
// queue, outstanding-WG counter and completion routing back to the owner.
module wg_id_pool #(
    parameter int NUM_QUEUES   = 2,
    parameter int QID_WIDTH    = 1,
    parameter int WG_ID_WIDTH  = 6,
    parameter int MAX_INFLIGHT = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc,
    input  logic [QID_WIDTH-1:0]   alloc_owner,
    output logic [WG_ID_WIDTH-1:0] alloc_id,
    output logic                   can_alloc,
    input  logic                   free_valid,
    input  logic [WG_ID_WIDTH-1:0] free_id,
    output logic [NUM_QUEUES-1:0]  done_vec,
    output logic [WG_ID_WIDTH:0]   inflight_count,
    output logic                   err_spurious
);

    localparam int POOL_SIZE = 1 << WG_ID_WIDTH;

    logic [POOL_SIZE-1:0] busy;
    logic [QID_WIDTH-1:0] owner [POOL_SIZE];
    logic                 free_hit;

    always_comb begin
        alloc_id = '0;
        for (int i = POOL_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_id = WG_ID_WIDTH'(i);
        end
    end

    assign can_alloc = !(&busy) && (inflight_count < (WG_ID_WIDTH + 1)'(MAX_INFLIGHT));
    assign free_hit  = free_valid && busy[free_id];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy           <= '0;
            // NOTE: the owner table is reset so a completion can never route an X owner onto q_wg_done.
            for (int i = 0; i < POOL_SIZE; i++) owner[i] <= '0;
            done_vec       <= '0;
            inflight_count <= '0;
            err_spurious   <= 1'b0;
        end else begin
            // NOTE: all state here uses <= so every read sees the pre-edge bitmap and owner table.
            done_vec <= '0;
            if (alloc) begin
                busy[alloc_id]  <= 1'b1;
                owner[alloc_id] <= alloc_owner;
            end
            if (free_hit) begin
                busy[free_id]            <= 1'b0;
                done_vec[owner[free_id]] <= 1'b1;
            end
            if (free_valid && !free_hit) err_spurious <= 1'b1;
            case ({alloc, free_hit})
                2'b10:   inflight_count <= inflight_count + 1'b1;
                2'b01:   inflight_count <= inflight_count - 1'b1;
                default: inflight_count <= inflight_count;
            endcase
        end
    end

endmodule

// File: rtl/dispatch_host_arbiter.sv
// Round-robin arbiter sharing the dispatcher host port between kernel queues;
// allocates a wg_id per accepted descriptor and routes completions back.
module dispatch_host_arbiter
    import dispatch_host_pkg::*;
#(
    parameter int NUM_QUEUES   = 2,
    parameter int QID_WIDTH    = 1,
    parameter int WG_ID_WIDTH  = 6,
    parameter int MAX_INFLIGHT = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_QUEUES-1:0]            q_valid,
    input  logic [NUM_QUEUES*DESC_WIDTH-1:0] q_desc,
    output logic [NUM_QUEUES-1:0]            q_ready,
    output logic [NUM_QUEUES-1:0]            q_wg_done,
    output logic                             host_wg_valid,
    output logic [WG_ID_WIDTH-1:0]           host_wg_id,
    output logic [WF_COUNT_WIDTH-1:0]        host_num_wf,
    output logic [VGPR_ID_WIDTH:0]           host_vgpr_size_per_wf,
    output logic [VGPR_ID_WIDTH:0]           host_vgpr_size_total,
    output logic [SGPR_ID_WIDTH:0]           host_sgpr_size_per_wf,
    output logic [SGPR_ID_WIDTH:0]           host_sgpr_size_total,
    output logic [LDS_ID_WIDTH:0]            host_lds_size_total,
    output logic [GDS_ID_WIDTH:0]            host_gds_size_total,
    output logic [WAVE_ITEM_WIDTH-1:0]       host_wf_size,
    output logic [MEM_ADDR_WIDTH-1:0]        host_start_pc,
    input  logic                             inflight_wg_buffer_host_rcvd_ack,
    input  logic                             inflight_wg_buffer_host_wf_done,
    input  logic [WG_ID_WIDTH-1:0]           inflight_wg_buffer_host_wf_done_wg_id,
    output logic [WG_ID_WIDTH:0]             inflight_count,
    output logic                             err_spurious_done
);

    arb_state_e             state;
    logic [QID_WIDTH-1:0]   rr_ptr;
    logic [QID_WIDTH-1:0]   cur_q;
    logic [QID_WIDTH-1:0]   win;
    logic [QID_WIDTH-1:0]   idx;
    logic                   found;
    logic                   can_alloc;
    logic                   grant;
    logic [WG_ID_WIDTH-1:0] alloc_id;
    logic [DESC_WIDTH-1:0]  sel_desc;

    // First valid queue at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            idx = QID_WIDTH'((int'(rr_ptr) + k) % NUM_QUEUES);
            if (!found && q_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant    = (state == ST_IDLE) && found && can_alloc;
    assign sel_desc = q_desc[win*DESC_WIDTH +: DESC_WIDTH];

    always_comb begin
        q_ready = '0;
        if (grant) q_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= ST_IDLE;
            rr_ptr                <= '0;
            cur_q                 <= '0;
            host_wg_valid         <= 1'b0;
            host_wg_id            <= '0;
            host_num_wf           <= '0;
            host_vgpr_size_per_wf <= '0;
            host_vgpr_size_total  <= '0;
            host_sgpr_size_per_wf <= '0;
            host_sgpr_size_total  <= '0;
            host_lds_size_total   <= '0;
            host_gds_size_total   <= '0;
            host_wf_size          <= '0;
            host_start_pc         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state                 <= ST_PRESENT;
                        host_wg_valid         <= 1'b1;
                        host_wg_id            <= alloc_id;
                        cur_q                 <= win;
                        host_num_wf           <= sel_desc[OFF_NUM_WF      +: WF_COUNT_WIDTH];
                        host_vgpr_size_per_wf <= sel_desc[OFF_VGPR_PER_WF +: VGPR_ID_WIDTH + 1];
                        host_vgpr_size_total  <= sel_desc[OFF_VGPR_TOTAL  +: VGPR_ID_WIDTH + 1];
                        host_sgpr_size_per_wf <= sel_desc[OFF_SGPR_PER_WF +: SGPR_ID_WIDTH + 1];
                        host_sgpr_size_total  <= sel_desc[OFF_SGPR_TOTAL  +: SGPR_ID_WIDTH + 1];
                        host_lds_size_total   <= sel_desc[OFF_LDS_TOTAL   +: LDS_ID_WIDTH + 1];
                        host_gds_size_total   <= sel_desc[OFF_GDS_TOTAL   +: GDS_ID_WIDTH + 1];
                        host_wf_size          <= sel_desc[OFF_WF_SIZE     +: WAVE_ITEM_WIDTH];
                        host_start_pc         <= sel_desc[OFF_START_PC    +: MEM_ADDR_WIDTH];
                    end
                end
                ST_PRESENT: begin
                    if (inflight_wg_buffer_host_rcvd_ack) begin
                        state         <= ST_IDLE;
                        host_wg_valid <= 1'b0;
                        rr_ptr        <= (cur_q == QID_WIDTH'(NUM_QUEUES - 1)) ? '0 : cur_q + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wg_id_pool #(
        .NUM_QUEUES  (NUM_QUEUES),
        .QID_WIDTH   (QID_WIDTH),
        .WG_ID_WIDTH (WG_ID_WIDTH),
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_pool (
        .clk           (clk),
        .rst           (rst),
        .alloc         (grant),
        .alloc_owner   (win),
        .alloc_id      (alloc_id),
        .can_alloc     (can_alloc),
        .free_valid    (inflight_wg_buffer_host_wf_done),
        .free_id       (inflight_wg_buffer_host_wf_done_wg_id),
        .done_vec      (q_wg_done),
        .inflight_count(inflight_count),
        .err_spurious  (err_spurious_done)
    );

endmodule
